acc_group: RTL and testbench

//  Stage directly downstream of MUL: per lane, sums the GROUP_SIZE products MUL emits over num_reads_per_iter reads.

---
 rtl/acc_group.sv | 104 ++++++++++
 tb/tb_acc_group.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_group.sv
// acc_group: per-lane accumulation of GROUP_SIZE products over num_reads_per_iter reads, one registered sum vector per iteration.
module acc_group #(
  parameter int GROUP_SIZE             = 4,
  parameter int DATA_WIDTH             = 8,
  parameter int ACC_WIDTH              = 32,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  configure,
  input  logic [LOG_MAX_ITERS-1:0]              num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]     num_reads_per_iter,
  input  logic [GROUP_SIZE*2*DATA_WIDTH-1:0]    data_in,
  input  logic                                  valid_in,
  output logic                                  avail_out,
  output logic [GROUP_SIZE*ACC_WIDTH-1:0]       data_out,
  output logic                                  valid_out,
  input  logic                                  avail_in,
  output logic                                  done
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int VW = GROUP_SIZE * ACC_WIDTH;
  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [LI-1:0] iters_q, iters_d;
  logic [LR-1:0] reads_q, reads_d, rcfg_q, rcfg_d;
  logic [VW-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic          valid_q, valid_d, done_q, done_d;
  logic          accept, last, xfer, counts_ok;

  for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
    assign sum[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g*ACC_WIDTH +: ACC_WIDTH] + ACC_WIDTH'(data_in[g*PW +: PW]);
  end

  // Only avail_in reaches avail_out combinationally; a draining output frees the slot this cycle.
  assign avail_out = (state_q == ACCUM) & (~valid_q | avail_in);
  assign accept    = valid_in & avail_out;
  assign last      = accept & (reads_q == LR'(1));
  assign xfer      = valid_q & avail_in;
  assign counts_ok = (num_iters != '0) & (num_reads_per_iter != '0);
  assign data_out  = out_q;
  assign valid_out = valid_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    reads_d = reads_q;
    rcfg_d  = rcfg_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q & ~xfer;
    done_d  = (state_q == FLUSH) & xfer;
    if (configure) begin
      iters_d = num_iters;
      reads_d = num_reads_per_iter;
      rcfg_d  = num_reads_per_iter;
      acc_d   = '0;
      valid_d = 1'b0;
      state_d = counts_ok ? ACCUM : IDLE;
      done_d  = ~counts_ok;
    end else begin
      if (state_q == FLUSH && xfer) state_d = IDLE;
      if (last) begin
        out_d   = sum;
        acc_d   = '0;
        valid_d = 1'b1;
        reads_d = rcfg_q;
        iters_d = iters_q - LI'(1);
        state_d = (iters_q == LI'(1)) ? FLUSH : ACCUM;
      end else if (accept) begin
        acc_d   = sum;
        reads_d = reads_q - LR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iters_q <= '0;
      reads_q <= '0;
      rcfg_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      reads_q <= reads_d;
      rcfg_q  <= rcfg_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_acc_group.sv
// tb_acc_group: directed tests of acc_group (32-bit lanes, plus a 16-bit-lane copy for wrap).
module tb_acc_group;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         configure = 1'b0;
  logic [15:0]  num_iters = '0;
  logic [15:0]  num_reads = '0;
  logic [63:0]  data_in = '0;
  logic         valid_in = 1'b0;
  logic         avail_in = 1'b0;
  logic         avail_out, valid_out, done;
  logic [127:0] data_out;
  logic         avail_out16, valid_out16, done16;
  logic [63:0]  data_out16;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  acc_group dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
    .avail_in(avail_in), .done(done)
  );

  acc_group #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out16), .data_out(data_out16), .valid_out(valid_out16),
    .avail_in(avail_in), .done(done16)
  );

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] ex(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [15:0] it, input logic [15:0] rd);
    valid_in  = 1'b0;
    configure = 1'b1;
    num_iters = it;
    num_reads = rd;
    cyc();
    configure = 1'b0;
    num_iters = 16'hFFFF;
    num_reads = 16'hFFFF;
  endtask

  task automatic feed(input logic [63:0] d);
    valid_in = 1'b1;
    data_in  = d;
    cyc();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (avail_out !== 1'b0 || valid_out !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL reset_state avail=%b valid=%b done=%b data=%h expected all 0", avail_out, valid_out, done, data_out);
    end
    cyc();
    rst = 1'b1;
    cyc();
    avail_in = 1'b0;
    do_cfg(2, 2);
    feed(pk(1, 1, 1, 1));
    feed(pk(1, 1, 1, 1));
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(2, 2, 2, 2)) begin
      failures++;
      $display("FAIL pre_reset_out valid=%b data=%h expected 1 %h", valid_out, data_out, ex(2, 2, 2, 2));
    end
    avail_in = 1'b1;
    feed(pk(7, 7, 7, 7));
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (avail_out !== 1'b0 || valid_out !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL async_reset avail=%b valid=%b done=%b data=%h expected all 0", avail_out, valid_out, done, data_out);
    end
    cyc();
    rst = 1'b1;
    valid_in = 1'b1;
    cyc();
    cyc();
    checks++;
    if (avail_out !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset avail=%b valid=%b expected 0 0", avail_out, valid_out);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_basic();
    avail_in = 1'b1;
    do_cfg(2, 3);
    feed(pk(1, 2, 3, 4));
    feed(pk(1, 2, 3, 4));
    feed(pk(1, 2, 3, 4));
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(3, 6, 9, 12)) begin
      failures++;
      $display("FAIL basic_out1 valid=%b data=%h expected 1 %h", valid_out, data_out, ex(3, 6, 9, 12));
    end
    feed(pk(10, 20, 30, 40));
    feed(pk(10, 20, 30, 40));
    checks++;
    if (avail_out !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_mid avail=%b valid=%b expected 1 0", avail_out, valid_out);
    end
    feed(pk(10, 20, 30, 40));
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(30, 60, 90, 120) || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_out2 valid=%b done=%b data=%h expected 1 0 %h", valid_out, done, data_out, ex(30, 60, 90, 120));
    end
    cyc();
    checks++;
    if (done !== 1'b1 || valid_out !== 1'b0 || avail_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_done done=%b valid=%b avail=%b expected 1 0 0", done, valid_out, avail_out);
    end
    cyc();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    avail_in = 1'b0;
    do_cfg(2, 3);
    feed(pk(1, 2, 3, 4));
    feed(pk(1, 2, 3, 4));
    feed(pk(1, 2, 3, 4));
    data_in = pk(10, 20, 30, 40);
    #1;
    checks++;
    if (avail_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_avail_out avail=%b expected 0", avail_out);
    end
    cyc();
    cyc();
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(3, 6, 9, 12)) begin
      failures++;
      $display("FAIL bp_hold valid=%b data=%h expected 1 %h", valid_out, data_out, ex(3, 6, 9, 12));
    end
    avail_in = 1'b1;
    feed(pk(10, 20, 30, 40));
    feed(pk(10, 20, 30, 40));
    feed(pk(10, 20, 30, 40));
    valid_in = 1'b0;
    avail_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(30, 60, 90, 120)) begin
      failures++;
      $display("FAIL bp_out2 valid=%b data=%h expected 1 %h", valid_out, data_out, ex(30, 60, 90, 120));
    end
    cyc();
    checks++;
    if (valid_out !== 1'b1 || done !== 1'b0 || data_out !== ex(30, 60, 90, 120)) begin
      failures++;
      $display("FAIL bp_out2_hold valid=%b done=%b data=%h expected 1 0 %h", valid_out, done, data_out, ex(30, 60, 90, 120));
    end
    avail_in = 1'b1;
    cyc();
    checks++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_done done=%b valid=%b expected 1 0", done, valid_out);
    end
  endtask

  task automatic test_wrap();
    avail_in = 1'b0;
    do_cfg(1, 2);
    feed(pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    feed(pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    valid_in = 1'b0;
    checks++;
    if (valid_out16 !== 1'b1 || data_out16 !== {4{16'hFFFE}}) begin
      failures++;
      $display("FAIL wrap16 valid=%b data=%h expected 1 %h", valid_out16, data_out16, {4{16'hFFFE}});
    end
    checks++;
    if (data_out !== {4{32'h0001FFFE}}) begin
      failures++;
      $display("FAIL wrap32_nowrap data=%h expected %h", data_out, {4{32'h0001FFFE}});
    end
    avail_in = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    avail_in = 1'b1;
    do_cfg(5, 1);
    for (int k = 0; k < 5; k++) begin
      feed(pk(16'(k + 1), 16'(16'hFFFF - k), 16'(256 * k), 16'h8000));
      checks++;
      if (valid_out !== 1'b1 || data_out !== ex(32'(k + 1), 32'(16'hFFFF - k), 32'(256 * k), 32'h8000)) begin
        failures++;
        $display("FAIL b2b_out%0d valid=%b data=%h expected 1 %h", k, valid_out, data_out,
                 ex(32'(k + 1), 32'(16'hFFFF - k), 32'(256 * k), 32'h8000));
      end
    end
    valid_in = 1'b0;
    cyc();
    checks++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done done=%b valid=%b expected 1 0", done, valid_out);
    end
    cyc();
  endtask

  task automatic test_reconfigure();
    avail_in = 1'b1;
    do_cfg(2, 3);
    feed(pk(1, 2, 3, 4));
    feed(pk(1, 2, 3, 4));
    do_cfg(1, 2);
    feed(pk(10, 20, 30, 40));
    feed(pk(10, 20, 30, 40));
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== ex(20, 40, 60, 80)) begin
      failures++;
      $display("FAIL reconf_partial valid=%b data=%h expected 1 %h", valid_out, data_out, ex(20, 40, 60, 80));
    end
    cyc();
    cyc();
    avail_in = 1'b0;
    do_cfg(2, 1);
    feed(pk(5, 6, 7, 8));
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL reconf_pending_setup valid=%b expected 1", valid_out);
    end
    do_cfg(2, 1);
    checks++;
    if (valid_out !== 1'b0 || avail_out !== 1'b1) begin
      failures++;
      $display("FAIL reconf_drop valid=%b avail=%b expected 0 1", valid_out, avail_out);
    end
    do_cfg(0, 3);
    checks++;
    if (done !== 1'b1 || valid_out !== 1'b0 || avail_out !== 1'b0) begin
      failures++;
      $display("FAIL zero_iters done=%b valid=%b avail=%b expected 1 0 0", done, valid_out, avail_out);
    end
    valid_in = 1'b1;
    cyc();
    checks++;
    if (done !== 1'b0 || valid_out !== 1'b0 || avail_out !== 1'b0) begin
      failures++;
      $display("FAIL zero_iters_idle done=%b valid=%b avail=%b expected 0 0 0", done, valid_out, avail_out);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reconfigure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
